// File: rtl/comparator_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// comparator_seq_ctrl_if
// Start/done handshake and operand/result bundle for comparator_seq_ctrl.
//   master : requester side (drives start_i, clear_i, a_i, b_i)
//   slave  : comparator side (drives busy_o, done_o, lt_o, eq_o, gt_o)
// Signals:
//   start_i  request a compare (accepted only when the comparator is idle/done)
//   clear_i  synchronous abort back to idle
//   a_i/b_i  operands, WIDTH bits each, sampled on the accepting edge
//   busy_o   compare in progress
//   done_o   one-cycle completion pulse
//   lt_o/eq_o/gt_o  registered result, held until the next completion
// -----------------------------------------------------------------------------
interface comparator_seq_ctrl_if #(
    parameter int WIDTH = 12
) ();
    logic             start_i;
    logic             clear_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             done_o;
    logic             lt_o;
    logic             eq_o;
    logic             gt_o;

    modport master (
        output start_i, clear_i, a_i, b_i,
        input  busy_o, done_o, lt_o, eq_o, gt_o
    );

    modport slave (
        input  start_i, clear_i, a_i, b_i,
        output busy_o, done_o, lt_o, eq_o, gt_o
    );
endinterface

// File: rtl/comparator_seq_ctrl.sv
// -----------------------------------------------------------------------------
// comparator_seq_ctrl
// Multi-cycle wide-word magnitude comparator. A single 3-bit comparator slice
// is time-shared: operands are walked LSB-first, three bits per cycle, and
// each slice result becomes the cascade input of the next (more significant)
// slice, so the final slice yields the full-width result.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    comparator_seq_ctrl_if.slave (start/clear/operands in,
//          busy/done/lt/eq/gt out)
// Parameters:
//   WIDTH  operand width, multiple of 3 and >= 3
//   SIGNED 1 = two's-complement compare
// -----------------------------------------------------------------------------

// 3-bit magnitude slice: local inequality wins, otherwise the cascade from the
// less significant slices is passed through.
module comparator_3bits (
    input  logic [2:0] A,
    input  logic [2:0] B,
    input  logic       l,
    input  logic       e,
    input  logic       g,
    output logic       lt,
    output logic       et,
    output logic       gt
);
    // Slice decision with cascade pass-through on local equality
    always_comb begin
        lt = 1'b0;
        et = 1'b0;
        gt = 1'b0;
        if (A > B) begin
            gt = 1'b1;
        end else if (A < B) begin
            lt = 1'b1;
        end else begin
            lt = l;
            et = e;
            gt = g;
        end
    end
endmodule

module comparator_seq_ctrl #(
    parameter int WIDTH  = 12,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    comparator_seq_ctrl_if.slave  bus
);
    localparam int NSLICE = WIDTH / 3;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NSLICE - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO  = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    // Flipping the sign bit maps two's complement onto offset binary, which
    // orders correctly under the unsigned slice chain.
    localparam logic [WIDTH-1:0] SIGN_MASK =
        (SIGNED != 0) ? (WIDTH'(1) << (WIDTH - 1)) : WIDTH'(0);
    localparam logic [2:0] CASC_EQ = 3'b010;

    generate
        if (((WIDTH % 3) != 0) || (WIDTH < 3)) begin : g_bad_width
            $error("comparator_seq_ctrl: WIDTH must be a multiple of 3 and >= 3");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_r;
    logic [IDX_W-1:0] idx_r;
    logic [WIDTH-1:0] a_sh_r;      // operand A, current slice in bits [2:0]
    logic [WIDTH-1:0] b_sh_r;      // operand B, current slice in bits [2:0]
    logic [2:0]       casc_r;      // {l,e,g} from less significant slices
    logic             busy_r;
    logic             done_r;
    logic             lt_r;
    logic             eq_r;
    logic             gt_r;

    logic             slice_lt_s;
    logic             slice_et_s;
    logic             slice_gt_s;
    logic             accept_s;

    comparator_3bits u_slice (
        .A  (a_sh_r[2:0]),
        .B  (b_sh_r[2:0]),
        .l  (casc_r[2]),
        .e  (casc_r[1]),
        .g  (casc_r[0]),
        .lt (slice_lt_s),
        .et (slice_et_s),
        .gt (slice_gt_s)
    );

    // A new request is taken only when no compare is in flight
    always_comb begin
        accept_s = 1'b0;
        if (bus.start_i && ((state_r == ST_IDLE) || (state_r == ST_DONE))) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Control FSM, operand shifters, cascade and registered results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= IDX_ZERO;
            a_sh_r  <= WIDTH'(0);
            b_sh_r  <= WIDTH'(0);
            casc_r  <= CASC_EQ;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            lt_r    <= 1'b0;
            eq_r    <= 1'b0;
            gt_r    <= 1'b0;
        end else if (bus.clear_i) begin
            // Abort: results of the last completed compare are kept
            state_r <= ST_IDLE;
            idx_r   <= IDX_ZERO;
            casc_r  <= CASC_EQ;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (accept_s) begin
                        a_sh_r  <= bus.a_i ^ SIGN_MASK;
                        b_sh_r  <= bus.b_i ^ SIGN_MASK;
                        idx_r   <= IDX_ZERO;
                        casc_r  <= CASC_EQ;
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    casc_r <= {slice_lt_s, slice_et_s, slice_gt_s};
                    a_sh_r <= a_sh_r >> 3'd3;
                    b_sh_r <= b_sh_r >> 3'd3;
                    if (idx_r == LAST_IDX) begin
                        idx_r   <= IDX_ZERO;
                        lt_r    <= slice_lt_s;
                        eq_r    <= slice_et_s;
                        gt_r    <= slice_gt_s;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_DONE;
                    end else begin
                        idx_r   <= idx_r + IDX_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    idx_r   <= IDX_ZERO;
                    casc_r  <= CASC_EQ;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o = busy_r;
    assign bus.done_o = done_r;
    assign bus.lt_o   = lt_r;
    assign bus.eq_o   = eq_r;
    assign bus.gt_o   = gt_r;
endmodule

// File: tb/tb_comparator_seq_ctrl.sv
module tb_comparator_seq_ctrl;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        clear;
    logic [11:0] a;
    logic [11:0] b;

    int n_pass  = 0;
    int n_total = 0;
    int sel     = 0;   // 0: 12-bit unsigned, 1: 12-bit signed, 2: 3-bit unsigned
    int dn0     = 0;   // done pulses seen on the 12-bit unsigned instance

    logic [2:0] exp_q[$];

    comparator_seq_ctrl_if #(.WIDTH(12)) if0 ();
    comparator_seq_ctrl_if #(.WIDTH(12)) if1 ();
    comparator_seq_ctrl_if #(.WIDTH(3))  if2 ();

    assign if0.start_i = start;  assign if0.clear_i = clear;
    assign if0.a_i     = a;      assign if0.b_i     = b;
    assign if1.start_i = start;  assign if1.clear_i = clear;
    assign if1.a_i     = a;      assign if1.b_i     = b;
    assign if2.start_i = start;  assign if2.clear_i = clear;
    assign if2.a_i     = a[2:0]; assign if2.b_i     = b[2:0];

    comparator_seq_ctrl #(.WIDTH(12), .SIGNED(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    comparator_seq_ctrl #(.WIDTH(12), .SIGNED(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    comparator_seq_ctrl #(.WIDTH(3),  .SIGNED(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (if0.done_o === 1'b1) dn0 <= dn0 + 1;

    logic       d_busy;
    logic       d_done;
    logic [2:0] d_res;
    always_comb begin
        case (sel)
            0: begin d_busy = if0.busy_o; d_done = if0.done_o; d_res = {if0.lt_o, if0.eq_o, if0.gt_o}; end
            1: begin d_busy = if1.busy_o; d_done = if1.done_o; d_res = {if1.lt_o, if1.eq_o, if1.gt_o}; end
            default: begin d_busy = if2.busy_o; d_done = if2.done_o; d_res = {if2.lt_o, if2.eq_o, if2.gt_o}; end
        endcase
    end

    // Reference: {lt, eq, gt}
    function automatic logic [2:0] model(input int s, input logic [11:0] av, input logic [11:0] bv);
        logic [2:0] r;
        if (s == 1) begin
            r = {$signed(av) < $signed(bv), av == bv, $signed(av) > $signed(bv)};
        end else if (s == 2) begin
            r = {av[2:0] < bv[2:0], av[2:0] == bv[2:0], av[2:0] > bv[2:0]};
        end else begin
            r = {av < bv, av == bv, av > bv};
        end
        return r;
    endfunction

    task automatic pulse_start(input logic [11:0] av, input logic [11:0] bv, input bit push);
        a = av; b = bv; start = 1'b1;
        if (push) exp_q.push_back(model(sel, av, bv));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Call just after an edge; returns at the negedge of the done cycle.
    task automatic wait_done(input int max, output int cyc, output int bcnt, output bit ok);
        ok = 1'b0; cyc = 0; bcnt = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (d_done === 1'b1) begin ok = 1'b1; break; end
            if (d_busy === 1'b1) bcnt++;
            @(posedge clk);
            cyc++;
        end
        if (!ok) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; clear = 1'b0; a = 12'h000; b = 12'h000;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            start = ~start; a = 12'(($urandom)); b = 12'(($urandom));
        end
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            n_total++;
            if ({d_busy, d_done} !== 2'b00) $display("FAIL reset_busy_done inst=%0d got=%b want=00", s, {d_busy, d_done});
            else n_pass++;
            n_total++;
            if (d_res !== 3'b000) $display("FAIL reset_result inst=%0d got=%b want=000", s, d_res);
            else n_pass++;
        end
        @(posedge clk); #1;
        start = 1'b0; rst_n = 1'b1;
    endtask

    // Single compare on the selected instance with latency/busy/result checks.
    task automatic run_one(input string nm, input logic [11:0] av, input logic [11:0] bv, input int lat);
        int cyc, bcnt; bit ok; logic [2:0] e;
        pulse_start(av, bv, 1'b1);
        wait_done(lat + 6, cyc, bcnt, ok);
        n_total++;
        if (!ok || cyc != lat || bcnt != lat)
            $display("FAIL %s_latency got done=%0d cyc=%0d busy=%0d want cyc=%0d busy=%0d", nm, ok, cyc, bcnt, lat, lat);
        else n_pass++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bxxx;
        n_total++;
        if (d_res !== e) $display("FAIL %s_result got=%b want=%b", nm, d_res, e);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (d_done !== 1'b0) $display("FAIL %s_done_width got=%b want=0", nm, d_done);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned;
        sel = 0;
        run_one("u_800_7ff", 12'h800, 12'h7FF, 4);
        run_one("u_abc_eq",  12'hABC, 12'hABC, 4);
        run_one("u_lsb_gt",  12'hABD, 12'hABC, 4);
        run_one("u_msb_lt",  12'h1FF, 12'h800, 4);
    endtask

    task automatic test_signed;
        sel = 1;
        run_one("s_min_lt", 12'h800, 12'h001, 4);
        run_one("s_neg_gt", 12'hFFF, 12'hFFE, 4);
        run_one("s_max_gt", 12'h7FF, 12'h800, 4);
    endtask

    task automatic test_width3;
        sel = 2;
        run_one("w3_gt", 12'h005, 12'h003, 1);
        run_one("w3_lt", 12'h002, 12'h007, 1);
    endtask

    task automatic test_back_to_back;
        int cyc, bcnt, d0; bit ok; logic [2:0] e;
        sel = 0; d0 = dn0;
        pulse_start(12'h100, 12'h200, 1'b1);
        a = 12'hFFF; b = 12'h000; start = 1'b1;   // ignored while running
        @(posedge clk); @(posedge clk); #1;
        start = 1'b0;
        wait_done(8, cyc, bcnt, ok);
        n_total++;
        if (!ok || cyc != 2) $display("FAIL b2b_first_latency got done=%0d cyc=%0d want cyc=2", ok, cyc);
        else n_pass++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bxxx;
        n_total++;
        if (d_res !== e) $display("FAIL b2b_first_result got=%b want=%b", d_res, e);
        else n_pass++;
        // New request held during the done cycle
        pulse_start(12'h555, 12'h555, 1'b1);
        wait_done(10, cyc, bcnt, ok);
        n_total++;
        if (!ok || cyc != 4) $display("FAIL b2b_second_latency got done=%0d cyc=%0d want cyc=4", ok, cyc);
        else n_pass++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bxxx;
        n_total++;
        if (d_res !== e) $display("FAIL b2b_second_result got=%b want=%b", d_res, e);
        else n_pass++;
        repeat (6) @(negedge clk);
        n_total++;
        if (dn0 - d0 != 2) $display("FAIL b2b_done_count got=%0d want=2", dn0 - d0);
        else n_pass++;
    endtask

    task automatic test_abort;
        int cyc, bcnt, d0; bit ok; logic [2:0] e;
        sel = 0;
        // Done cycle of a fresh compare, then clear+start together: clear wins
        pulse_start(12'h333, 12'h333, 1'b1);
        wait_done(10, cyc, bcnt, ok);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bxxx;
        n_total++;
        if (!ok || d_res !== e) $display("FAIL abort_setup got done=%0d res=%b want done=1 res=%b", ok, d_res, e);
        else n_pass++;
        a = 12'h000; b = 12'h001; start = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; clear = 1'b0;
        @(negedge clk);
        n_total++;
        if ({d_busy, d_done} !== 2'b00) $display("FAIL clear_priority got busy/done=%b want=00", {d_busy, d_done});
        else n_pass++;
        // Clear in the second RUN cycle
        d0 = dn0;
        pulse_start(12'h001, 12'h002, 1'b0);
        @(posedge clk); #1; clear = 1'b1;
        @(posedge clk); #1; clear = 1'b0;
        repeat (6) @(negedge clk);
        n_total++;
        if (dn0 != d0 || d_busy !== 1'b0) $display("FAIL abort_no_done got dones=%0d busy=%b want dones=0 busy=0", dn0 - d0, d_busy);
        else n_pass++;
        n_total++;
        if (d_res !== 3'b010) $display("FAIL abort_held_result got=%b want=010", d_res);
        else n_pass++;
        // Reset mid-run
        @(posedge clk); #1;
        d0 = dn0;
        pulse_start(12'h003, 12'h001, 1'b0);
        @(posedge clk); #1; rst_n = 1'b0; #1;
        n_total++;
        if ({d_busy, d_done, d_res} !== 5'b00000) $display("FAIL rst_mid_run got=%b want=00000", {d_busy, d_done, d_res});
        else n_pass++;
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_total++;
        if (dn0 != d0) $display("FAIL rst_no_done got dones=%0d want=0", dn0 - d0);
        else n_pass++;
        @(posedge clk); #1;
        run_one("post_rst", 12'h003, 12'h001, 4);
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_width3;
        sel = 0;
        test_back_to_back;
        test_abort;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
